bidir_delay_calib_ctrl: RTL and testbench

//  Synchronous calibration controller for a tapped chain of bidirDelay1U stages.
//  - Runs repeated 4-phase req/ack cycles through the selected tap.
//  - Counts clock cycles per phase and reports the average per-phase round-trip.
//  - Flags a timeout if the chain never answers.
//  - Sits between the config/CSR logic and the async delay-chain macro.

---
 rtl/bidir_delay_calib_ctrl_pkg.sv | 22 ++
 rtl/bidir_delay_calib_ctrl_sync2.sv | 30 +++
 rtl/bidir_delay_calib_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_bidir_delay_calib_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bidir_delay_calib_ctrl_pkg.sv
// Package: bidir_delay_calib_ctrl_pkg
// Purpose : Shared definitions for the delay-chain calibration controller:
//           FSM state encodings and the default settle/timeout cycle counts.
// Contents:
//   calState_t      - controller FSM states
//   TIMEOUT_DEF     - default max cycles per phase (must stay below 2^CNT_W)
//   SETTLE_CYC_DEF  - default quiet cycles required after a tap change
package bidir_delay_calib_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        RISE   = 3'd2,
        FALL   = 3'd3,
        ERR    = 3'd4,
        FIN    = 3'd5
    } calState_t;

    localparam int TIMEOUT_DEF    = 4000;
    localparam int SETTLE_CYC_DEF = 4;

endpackage

// File: rtl/bidir_delay_calib_ctrl_sync2.sv
// Module : sync2
// Purpose: Two-flop synchronizer for a single asynchronous level, cleared
//          to 0 by a synchronous active-high reset. Shared by the async
//          bridges around the delay-chain macros.
// Ports  :
//   clk  in  1  destination clock
//   rst  in  1  synchronous active-high reset
//   d    in  1  asynchronous input level
//   q    out 1  synchronized level (two clocks of latency)
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic metaR;

    // Two-stage capture of the asynchronous level.
    always_ff @(posedge clk) begin
        if (rst) begin
            metaR <= 1'b0;
            q     <= 1'b0;
        end else begin
            metaR <= d;
            q     <= metaR;
        end
    end

endmodule

// File: rtl/bidir_delay_calib_ctrl.sv
// Module : bidir_delay_calib_ctrl
// Purpose: Calibrates a tapped chain of bidirectional delay stages by running
//          2^SAMPLES_LOG2 four-phase req/ack cycles through the selected tap,
//          counting clocks per phase and reporting the average per phase.
//          A chain that never answers ends the run with timeout_err set.
// Ports  :
//   clk          in   1      single clock, rising edge
//   rst          in   1      synchronous active-high reset
//   start        in   1      one-cycle pulse to begin a run (ignored while busy)
//   tap_sel_in   in   TAP_W  requested tap, sampled on an accepted start
//   busy         out  1      high from accepted start through the done cycle
//   done         out  1      one-cycle pulse at end of run
//   timeout_err  out  1      valid with done, held until next accepted start
//   result       out  CNT_W  average cycles per phase, held until next start
//   tap_sel      out  TAP_W  registered tap select to the chain mux
//   inR          out  1      registered request into the chain
//   inA          in   1      asynchronous acknowledge from the chain
module bidir_delay_calib_ctrl
    import bidir_delay_calib_ctrl_pkg::*;
#(
    parameter int TAP_W        = 3,
    parameter int CNT_W        = 12,
    parameter int SAMPLES_LOG2 = 3,
    parameter int SETTLE_CYC   = SETTLE_CYC_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [TAP_W-1:0] tap_sel_in,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] result,
    output logic [TAP_W-1:0] tap_sel,
    output logic             inR,
    input  logic             inA
);

    // Sum of 2^(SAMPLES_LOG2+1) phase counts, each at most TIMEOUT < 2^CNT_W.
    localparam int SUM_W = CNT_W + SAMPLES_LOG2 + 1;

    localparam logic [CNT_W-1:0]        CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]        CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0]        SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]        TIMEOUT_C    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]        TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [SAMPLES_LOG2-1:0] IDX_ZERO     = {SAMPLES_LOG2{1'b0}};
    localparam logic [SAMPLES_LOG2-1:0] IDX_ONE      = SAMPLES_LOG2'(1);
    localparam logic [SAMPLES_LOG2-1:0] IDX_LAST     = {SAMPLES_LOG2{1'b1}};
    localparam logic [SUM_W-1:0]        SUM_ZERO     = {SUM_W{1'b0}};

    calState_t               stateR, nextState;
    logic [CNT_W-1:0]        cntR, cntNext;
    logic [CNT_W-1:0]        totR, totNext;
    logic [SUM_W-1:0]        sumR, sumNext, phaseSum;
    logic [SAMPLES_LOG2-1:0] idxR, idxNext;
    logic                    inRNext, busyNext, doneNext, errNext;
    logic [CNT_W-1:0]        resultNext;
    logic [TAP_W-1:0]        tapNext;
    logic                    ackS;

    sync2 uAckSync (
        .clk (clk),
        .rst (rst),
        .d   (inA),
        .q   (ackS)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateR <= IDLE;
        end else begin
            stateR <= nextState;
        end
    end

    // Next-state, counter, accumulator and output-register next values.
    always_comb begin
        nextState  = stateR;
        cntNext    = cntR;
        totNext    = totR;
        sumNext    = sumR;
        idxNext    = idxR;
        inRNext    = inR;
        busyNext   = busy;
        doneNext   = 1'b0;
        errNext    = timeout_err;
        resultNext = result;
        tapNext    = tap_sel;
        // Accumulator value once the phase that is finishing now is added in.
        phaseSum   = sumR + SUM_W'(cntR);

        case (stateR)
            IDLE: begin
                if (start) begin
                    tapNext   = tap_sel_in;
                    sumNext   = SUM_ZERO;
                    cntNext   = CNT_ZERO;
                    totNext   = CNT_ZERO;
                    idxNext   = IDX_ZERO;
                    errNext   = 1'b0;
                    busyNext  = 1'b1;
                    nextState = SETTLE;
                end else begin
                    busyNext  = 1'b0;
                end
            end

            SETTLE: begin
                // cnt tracks consecutive quiet cycles, tot the whole stay here.
                if (!ackS && (cntR == SETTLE_LAST)) begin
                    cntNext   = CNT_ZERO;
                    inRNext   = 1'b1;
                    nextState = RISE;
                end else if (totR == TIMEOUT_LAST) begin
                    cntNext   = CNT_ZERO;
                    inRNext   = 1'b0;
                    nextState = ERR;
                end else if (ackS) begin
                    cntNext   = CNT_ZERO;
                    totNext   = totR + CNT_ONE;
                end else begin
                    cntNext   = cntR + CNT_ONE;
                    totNext   = totR + CNT_ONE;
                end
            end

            RISE: begin
                if (ackS) begin
                    sumNext   = phaseSum;
                    cntNext   = CNT_ZERO;
                    inRNext   = 1'b0;
                    nextState = FALL;
                end else if (cntR == TIMEOUT_C) begin
                    cntNext   = CNT_ZERO;
                    inRNext   = 1'b0;
                    nextState = ERR;
                end else begin
                    cntNext   = cntR + CNT_ONE;
                end
            end

            FALL: begin
                if (!ackS) begin
                    sumNext = phaseSum;
                    cntNext = CNT_ZERO;
                    idxNext = idxR + IDX_ONE;
                    if (idxR == IDX_LAST) begin
                        // Divide by the number of phases, truncating.
                        resultNext = phaseSum[SUM_W-1:SAMPLES_LOG2+1];
                        doneNext   = 1'b1;
                        nextState  = FIN;
                    end else begin
                        inRNext    = 1'b1;
                        nextState  = RISE;
                    end
                end else if (cntR == TIMEOUT_C) begin
                    cntNext   = CNT_ZERO;
                    inRNext   = 1'b0;
                    nextState = ERR;
                end else begin
                    cntNext   = cntR + CNT_ONE;
                end
            end

            ERR: begin
                // Request is already low; give the chain a bounded chance to drop ack.
                inRNext = 1'b0;
                if (!ackS || (cntR == TIMEOUT_C)) begin
                    errNext    = 1'b1;
                    resultNext = {CNT_W{1'b1}};
                    doneNext   = 1'b1;
                    nextState  = FIN;
                end else begin
                    cntNext    = cntR + CNT_ONE;
                end
            end

            FIN: begin
                busyNext  = 1'b0;
                nextState = IDLE;
            end

            default: begin
                busyNext  = 1'b0;
                inRNext   = 1'b0;
                nextState = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cntR        <= CNT_ZERO;
            totR        <= CNT_ZERO;
            sumR        <= SUM_ZERO;
            idxR        <= IDX_ZERO;
            inR         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            result      <= CNT_ZERO;
            tap_sel     <= {TAP_W{1'b0}};
        end else begin
            cntR        <= cntNext;
            totR        <= totNext;
            sumR        <= sumNext;
            idxR        <= idxNext;
            inR         <= inRNext;
            busy        <= busyNext;
            done        <= doneNext;
            timeout_err <= errNext;
            result      <= resultNext;
            tap_sel     <= tapNext;
        end
    end

endmodule

// File: tb/tb_bidir_delay_calib_ctrl.sv
// Testbench for bidir_delay_calib_ctrl: a behavioural chain model (loopback,
// stuck levels, per-edge delays) drives inA; a run-level model predicts
// result, timeout flag, tap and request-edge count, and a compare process
// checks the DUT against it every cycle.
module tb_bidir_delay_calib_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  tapSelIn;
    logic        busy;
    logic        done;
    logic        timeoutErr;
    logic [11:0] result;
    logic [2:0]  tapSel;
    logic        inR;
    logic        inA;

    int errors = 0;
    int checks = 0;

    // Chain model: 0 loopback, 1 stuck low, 2 stuck high, 3 delayed by dRise/dFall.
    int          mode  = 0;
    int          dRise = 0;
    int          dFall = 0;
    logic [63:0] hist  = 64'd0;
    logic        lagA  = 1'b0;

    // Expectations for the run in flight (p*) and the values held after it (h*).
    int pResult = 0, pErr = 0, pTap = 0, pRises = 0;
    int hResult = 0, hErr = 0, hTap = 0;
    int rises = 0;
    logic prevInR = 1'b0, prevBusy = 1'b0, prevDone = 1'b0;

    always #5 clk = ~clk;

    bidir_delay_calib_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .tap_sel_in  (tapSelIn),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeoutErr),
        .result      (result),
        .tap_sel     (tapSel),
        .inR         (inR),
        .inA         (inA)
    );

    assign inA = (mode == 0) ? inR  :
                 (mode == 1) ? 1'b0 :
                 (mode == 2) ? 1'b1 : lagA;

    // Ack follows the request once it has held its new level for dr (rise) or df (fall) clocks.
    function automatic logic nextLag(input logic cur, input logic [63:0] h, input int dr, input int df);
        logic [63:0] mr;
        logic [63:0] mf;
        mr = (64'd1 << dr) - 64'd1;
        mf = (64'd1 << df) - 64'd1;
        if (cur) return ((h & mf) == 64'd0) ? 1'b0 : 1'b1;
        else     return ((h & mr) == mr)    ? 1'b1 : 1'b0;
    endfunction

    always @(posedge clk) begin
        hist <= {hist[62:0], inR};
        lagA <= nextLag(lagA, {hist[62:0], inR}, dRise, dFall);
    end

    // Each phase costs 2 sync clocks plus the loop delay; 8 cycles = 16 phases averaged.
    function automatic int modelResult(input int dr, input int df);
        int sum;
        sum = ((2 + dr) + (2 + df)) * 8;
        return sum / 16;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulseStart(input logic [2:0] t);
        tapSelIn = t;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic expectRun(input int tap, input int res, input int err, input int nRises);
        pTap    = tap;
        pResult = res;
        pErr    = err;
        pRises  = nRises;
    endtask

    // Per-cycle comparison against the run-level model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hResult  = 0;
                hErr     = 0;
                hTap     = 0;
                rises    = 0;
                prevInR  = 1'b0;
                prevBusy = 1'b0;
                prevDone = 1'b0;
            end else begin
                if (busy && !prevBusy) rises = 0;
                if (inR && !prevInR) rises++;
                if (busy) check("tap_run", {29'd0, tapSel}, pTap);
                else      check("tap_idle", {29'd0, tapSel}, hTap);
                if (!busy) begin
                    check("inR_idle", {31'd0, inR}, 32'd0);
                    check("done_idle", {31'd0, done}, 32'd0);
                    check("result_held", {20'd0, result}, hResult);
                    check("err_held", {31'd0, timeoutErr}, hErr);
                end
                if (prevDone) check("busy_after_done", {31'd0, busy}, 32'd0);
                if (done && busy) begin
                    check("result_done", {20'd0, result}, pResult);
                    check("err_done", {31'd0, timeoutErr}, pErr);
                    check("rises_done", rises, pRises);
                    hResult = pResult;
                    hErr    = pErr;
                    hTap    = pTap;
                end
                prevInR  = inR;
                prevBusy = busy;
                prevDone = done;
            end
        end
    end

    // Directed stimulus.
    initial begin
        bit   seen;
        logic lastR;
        rst = 1'b1; start = 1'b0; tapSelIn = 3'd0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, timeoutErr}, 32'd0);
        check("rst_result", {20'd0, result}, 32'd0);
        check("rst_tap", {29'd0, tapSel}, 32'd0);
        check("rst_inR", {31'd0, inR}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1: zero-delay loopback on tap 3.
        mode = 0;
        expectRun(3, modelResult(0, 0), 0, 8);
        pulseStart(3'd3);
        waitDone(400, "t1_done_seen");
        check("t1_result", {20'd0, result}, 32'd2);
        check("t1_tap", {29'd0, tapSel}, 32'd3);
        check("t1_err", {31'd0, timeoutErr}, 32'd0);
        tick();

        // 2: symmetric 5-clock loop delay.
        mode = 3; dRise = 5; dFall = 5;
        expectRun(1, modelResult(5, 5), 0, 8);
        pulseStart(3'd1);
        waitDone(600, "t2_done_seen");
        check("t2_result", {20'd0, result}, 32'd7);
        check("t2_rises", rises, 32'd8);
        tick();

        // 3: asymmetric delay, rise 3 / fall 9.
        dRise = 3; dFall = 9;
        expectRun(4, modelResult(3, 9), 0, 8);
        pulseStart(3'd4);
        waitDone(600, "t3_done_seen");
        check("t3_result", {20'd0, result}, 32'd8);
        tick();

        // 4: ack stuck low -> RISE timeout.
        mode = 1;
        expectRun(5, 4095, 1, 1);
        pulseStart(3'd5);
        waitDone(10000, "t4_done_seen");
        check("t4_result", {20'd0, result}, 32'd4095);
        check("t4_err", {31'd0, timeoutErr}, 32'd1);
        check("t4_inR", {31'd0, inR}, 32'd0);
        tick();

        // 5: ack stuck high -> SETTLE timeout, request never raised.
        mode = 2;
        expectRun(2, 4095, 1, 0);
        pulseStart(3'd2);
        waitDone(12000, "t5_done_seen");
        check("t5_err", {31'd0, timeoutErr}, 32'd1);
        check("t5_rises", rises, 32'd0);
        tick();

        // 6: reset during FALL with extra starts while busy.
        mode = 3; dRise = 5; dFall = 5;
        expectRun(6, modelResult(5, 5), 0, 8);
        pulseStart(3'd6);
        seen = 1'b0; lastR = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (lastR && !inR) begin
                seen = 1'b1;
                break;
            end
            lastR = inR;
        end
        check("t6_fall_seen", {31'd0, seen}, 32'd1);
        tick();
        tapSelIn = 3'd1; start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1; start = 1'b1;
        tick();
        @(negedge clk);
        check("t6_rst_inR", {31'd0, inR}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_done", {31'd0, done}, 32'd0);
        tick();
        rst = 1'b0; start = 1'b0;
        repeat (20) tick();
        check("t6_post_busy", {31'd0, busy}, 32'd0);
        mode = 0;
        expectRun(3, modelResult(0, 0), 0, 8);
        pulseStart(3'd3);
        waitDone(400, "t6_done_seen");
        check("t6_result", {20'd0, result}, 32'd2);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
